// File: rtl/fast_nm_encoder_pkg.sv
// Shared widths, field positions and pmap constants for the FAST new-message encoder.
// Also carries the stage-1 record passed from the compare stage to the pack logic.
package fast_nm_encoder_pkg;

    localparam int MAX_MESSAGE_BITS  = 280;
    localparam int FAST_MESSAGE_BITS = 344;
    localparam int PMAP_B            = 343;
    localparam int PMAP_E            = 328;
    localparam int PAYLOAD_BITS      = PMAP_E;
    localparam int FIELD_W           = 8;
    localparam int TIME_W            = 32;

    localparam int PID_LSB  = 272;
    localparam int MC_LSB   = 264;
    localparam int MT_LSB   = 256;
    localparam int RSV_LSB  = 248;
    localparam int TIME_LSB = 216;

    // pmap bit 15 is the stop/presence bit and is always set.
    localparam logic [15:0] PMAP_BASE = 16'h8000;

    typedef struct packed {
        logic [FIELD_W-1:0] pid;
        logic [FIELD_W-1:0] mc;
        logic [FIELD_W-1:0] mt;
        logic [TIME_W-1:0]  tm;
        logic               c_pid;
        logic               c_mc;
        logic               c_mt;
    } s1_t;

endpackage

// File: rtl/fast_nm_encoder_pack.sv
// Combinational payload packer: present header fields then time, left-justified at bit 327.
// Zero latency; no flow control of its own.
module fast_nm_pack
    import fast_nm_encoder_pkg::*;
(
    input  logic                    c_pid_i,
    input  logic                    c_mc_i,
    input  logic                    c_mt_i,
    input  logic [FIELD_W-1:0]      pid_i,
    input  logic [FIELD_W-1:0]      mc_i,
    input  logic [FIELD_W-1:0]      mt_i,
    input  logic [TIME_W-1:0]       time_i,
    output logic [PAYLOAD_BITS-1:0] payload_o,
    output logic [3:0]              len_o
);

    logic [3*FIELD_W-1:0]        hdr_acc;
    logic [1:0]                  hdr_n;
    logic [3*FIELD_W+TIME_W-1:0] word;
    logic [4:0]                  shift;

    // Present fields are shifted into the low bytes of hdr_acc; the final shift
    // drops the leading empty bytes so the first present field lands on top.
    always_comb begin
        hdr_acc = '0;
        hdr_n   = '0;
        if (!c_pid_i) begin
            hdr_acc = {hdr_acc[2*FIELD_W-1:0], pid_i};
            hdr_n   = hdr_n + 2'd1;
        end
        if (!c_mc_i) begin
            hdr_acc = {hdr_acc[2*FIELD_W-1:0], mc_i};
            hdr_n   = hdr_n + 2'd1;
        end
        if (!c_mt_i) begin
            hdr_acc = {hdr_acc[2*FIELD_W-1:0], mt_i};
            hdr_n   = hdr_n + 2'd1;
        end
        shift     = {2'd3 - hdr_n, 3'b000};
        word      = {hdr_acc, time_i} << shift;
        payload_o = {word, {(PAYLOAD_BITS-3*FIELD_W-TIME_W){1'b0}}};
        len_o     = 4'd4 + {2'b00, hdr_n};
    end

endmodule

// File: rtl/fast_nm_encoder.sv
// FAST new-message encoder: copy-dictionary compare (S1) then packed output register (S2).
// Latency 2 cycles accept-to-out_valid; in_ready falls only when both stages are full and stalled.
module fast_nm_encoder
    import fast_nm_encoder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAX_MESSAGE_BITS-1:0]  in_message,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         dict_reset,
    output logic [FAST_MESSAGE_BITS-1:0] out_fast,
    output logic [3:0]                   out_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FIELD_W-1:0]           dict_pid,
    output logic [FIELD_W-1:0]           dict_mc,
    output logic [FIELD_W-1:0]           dict_mt,
    output logic                         dict_valid,
    output logic [15:0]                  msg_count
);

    s1_t                         s1_q, s1_d;
    logic                        s1_valid_q, s2_valid_q;
    logic [FAST_MESSAGE_BITS-1:0] out_fast_q;
    logic [3:0]                  out_len_q;
    logic [FIELD_W-1:0]          dict_pid_q, dict_mc_q, dict_mt_q;
    logic                        dict_valid_q;
    logic [15:0]                 msg_count_q;

    logic                        s1_advance, accept;
    logic [PAYLOAD_BITS-1:0]     pack_payload;
    logic [3:0]                  pack_len;
    logic [15:0]                 pmap;
    logic                        unused_msg_bits;

    assign unused_msg_bits = ^{in_message[RSV_LSB +: FIELD_W], in_message[TIME_LSB-1:0]};

    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign accept     = in_valid && in_ready;

    // A dict_reset in the accepting cycle forces every field to be sent.
    always_comb begin
        s1_d       = '0;
        s1_d.pid   = in_message[PID_LSB +: FIELD_W];
        s1_d.mc    = in_message[MC_LSB +: FIELD_W];
        s1_d.mt    = in_message[MT_LSB +: FIELD_W];
        s1_d.tm    = in_message[TIME_LSB +: TIME_W];
        s1_d.c_pid = dict_valid_q && !dict_reset && (s1_d.pid == dict_pid_q);
        s1_d.c_mc  = dict_valid_q && !dict_reset && (s1_d.mc == dict_mc_q);
        s1_d.c_mt  = dict_valid_q && !dict_reset && (s1_d.mt == dict_mt_q);
    end

    fast_nm_pack u_pack (
        .c_pid_i   (s1_q.c_pid),
        .c_mc_i    (s1_q.c_mc),
        .c_mt_i    (s1_q.c_mt),
        .pid_i     (s1_q.pid),
        .mc_i      (s1_q.mc),
        .mt_i      (s1_q.mt),
        .time_i    (s1_q.tm),
        .payload_o (pack_payload),
        .len_o     (pack_len)
    );

    assign pmap = PMAP_BASE | {1'b0, s1_q.c_pid, s1_q.c_mc, s1_q.c_mt, 12'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_fast_q   <= '0;
            out_len_q    <= '0;
            dict_pid_q   <= '0;
            dict_mc_q    <= '0;
            dict_mt_q    <= '0;
            dict_valid_q <= 1'b0;
            msg_count_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= accept;
                if (accept) s1_q <= s1_d;
            end
            if (s1_advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_fast_q <= {pmap, pack_payload};
                    out_len_q  <= pack_len;
                end
            end
            if (accept) begin
                dict_pid_q   <= s1_d.pid;
                dict_mc_q    <= s1_d.mc;
                dict_mt_q    <= s1_d.mt;
                dict_valid_q <= 1'b1;
            end else if (dict_reset) begin
                dict_pid_q   <= '0;
                dict_mc_q    <= '0;
                dict_mt_q    <= '0;
                dict_valid_q <= 1'b0;
            end
            if (s2_valid_q && out_ready) msg_count_q <= msg_count_q + 16'd1;
        end
    end

    assign out_fast   = out_fast_q;
    assign out_len    = out_len_q;
    assign out_valid  = s2_valid_q;
    assign dict_pid   = dict_pid_q;
    assign dict_mc    = dict_mc_q;
    assign dict_mt    = dict_mt_q;
    assign dict_valid = dict_valid_q;
    assign msg_count  = msg_count_q;

endmodule

// File: tb/tb_fast_nm_encoder.sv
// Directed bench for fast_nm_encoder with a byte-list reference model feeding a scoreboard.
module tb_fast_nm_encoder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [279:0] in_message = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         dict_reset = 1'b0;
    logic [343:0] out_fast;
    logic [3:0]   out_len;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   dict_pid, dict_mc, dict_mt;
    logic         dict_valid;
    logic [15:0]  msg_count;

    int checks = 0;
    int errors = 0;

    logic [347:0] sb[$];
    logic         m_valid = 1'b0;
    logic [7:0]   m_pid = '0, m_mc = '0, m_mt = '0;
    logic [15:0]  m_count = '0;
    logic [347:0] held = '0;
    logic         held_vld = 1'b0;
    logic         last_acc = 1'b0;

    fast_nm_encoder dut (
        .clk(clk), .rst(rst), .in_message(in_message), .in_valid(in_valid),
        .in_ready(in_ready), .dict_reset(dict_reset), .out_fast(out_fast),
        .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready),
        .dict_pid(dict_pid), .dict_mc(dict_mc), .dict_mt(dict_mt),
        .dict_valid(dict_valid), .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    function automatic logic [279:0] mk(input logic [7:0] pid, input logic [7:0] mc,
                                        input logic [7:0] mt, input logic [7:0] rsv,
                                        input logic [31:0] tm);
        return {pid, mc, mt, rsv, tm, 216'b0};
    endfunction

    // Expected {out_len, out_fast}, built byte by byte.
    function automatic logic [347:0] model(input logic cp, input logic cm, input logic ct,
                                           input logic [7:0] pid, input logic [7:0] mc,
                                           input logic [7:0] mt, input logic [31:0] tm);
        logic [7:0]   b[7];
        int           n;
        logic [327:0] pl;
        n = 0;
        if (!cp) begin b[n] = pid; n++; end
        if (!cm) begin b[n] = mc;  n++; end
        if (!ct) begin b[n] = mt;  n++; end
        for (int i = 0; i < 4; i++) begin b[n] = tm[31-8*i -: 8]; n++; end
        pl = '0;
        for (int i = 0; i < n; i++) pl[327-8*i -: 8] = b[i];
        return {4'(n), 1'b1, cp, cm, ct, 12'b0, pl};
    endfunction

    task automatic chk(input string tag, input logic [347:0] obs, input logic [347:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [279:0] msg, input logic dr,
                        input logic ordy, input logic r);
        logic [7:0]   pid, mc, mt;
        logic [31:0]  tm;
        logic         cp, cm, ct;
        logic [347:0] e;
        @(negedge clk);
        in_valid = v; in_message = msg; dict_reset = dr; out_ready = ordy; rst = r;
        #1;
        last_acc = 1'b0;
        if (r) begin
            sb.delete();
            m_valid = 0; m_pid = 0; m_mc = 0; m_mt = 0; m_count = 0; held_vld = 0;
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 348'(sb.size() != 0), 348'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", {out_len, out_fast}, e);
                end
                m_count++;
                held_vld = 0;
            end else if (out_valid) begin
                if (held_vld) chk("hold_stable", {out_len, out_fast}, held);
                held = {out_len, out_fast};
                held_vld = 1;
            end else begin
                held_vld = 0;
            end
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                pid = msg[279:272]; mc = msg[271:264]; mt = msg[263:256]; tm = msg[247:216];
                cp = m_valid && !dr && (pid == m_pid);
                cm = m_valid && !dr && (mc == m_mc);
                ct = m_valid && !dr && (mt == m_mt);
                sb.push_back(model(cp, cm, ct, pid, mc, mt, tm));
                m_valid = 1; m_pid = pid; m_mc = mc; m_mt = mt;
            end else if (dr) begin
                m_valid = 0; m_pid = 0; m_mc = 0; m_mt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dict(input string tag);
        chk({tag, "_dict"}, {dict_valid, dict_pid, dict_mc, dict_mt}, {m_valid, m_pid, m_mc, m_mt});
        chk({tag, "_count"}, msg_count, m_count);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(0, '0, 0, 1, 0);
        chk("drain_empty", sb.size(), 0);
    endtask

    logic [279:0] bp[6];
    int k, acc_n;

    initial begin
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 1, 0);
        chk("rst_state", {out_valid, msg_count, dict_valid, dict_pid, dict_mc, dict_mt, out_len},
            {1'b0, 16'h0, 1'b0, 24'h0, 4'h0});
        chk("rst_out_fast", out_fast, 0);
        chk("rst_in_ready", in_ready, 1);

        // First message: all fields present, 2-cycle latency.
        step(1, mk(8'h11, 8'h22, 8'h33, 8'h00, 32'hDEADBEEF), 0, 1, 0);
        chk("lat_s1_only", out_valid, 0);
        step(0, '0, 0, 0, 0);
        chk("lat_out_valid", out_valid, 1);
        chk("m1_pmap", out_fast[343:328], 16'h8000);
        chk("m1_bytes", out_fast[327:272], 56'h112233DEADBEEF);
        chk("m1_rest", out_fast[271:0], 0);
        chk("m1_len", out_len, 7);

        step(1, mk(8'h11, 8'h22, 8'h33, 8'h5A, 32'h00000001), 0, 1, 0);
        step(1, mk(8'h12, 8'h22, 8'h33, 8'h00, 32'h00000005), 0, 1, 0);
        chk_dict("after_m3");
        step(0, '0, 0, 0, 0);
        chk("m2_pmap", out_fast[343:328], 16'hF000);
        chk("m2_len", out_len, 4);
        step(0, '0, 0, 1, 0);
        chk("m3_pmap", out_fast[343:328], 16'hB000);
        chk("m3_bytes", out_fast[327:288], 40'h1200000005);
        drain();

        // dict_reset with and without a simultaneous accept.
        step(1, mk(8'h12, 8'h22, 8'h33, 8'hFF, 32'h00000007), 1, 1, 0);
        chk_dict("dr_accept");
        step(0, '0, 1, 1, 0);
        chk_dict("dr_alone");
        step(1, mk(8'h12, 8'h22, 8'h34, 8'h00, 32'h00000008), 0, 1, 0);
        step(1, mk(8'h12, 8'h23, 8'h34, 8'h00, 32'h00000009), 0, 1, 0);
        drain();
        chk_dict("after_dr");

        // Backpressure with in_valid held.
        bp[0] = mk(8'h40, 8'h41, 8'h42, 8'h00, 32'h100);
        bp[1] = mk(8'h40, 8'h41, 8'h43, 8'h00, 32'h101);
        bp[2] = mk(8'h44, 8'h41, 8'h43, 8'h00, 32'h102);
        bp[3] = mk(8'h44, 8'h45, 8'h43, 8'h00, 32'h103);
        bp[4] = mk(8'h44, 8'h45, 8'h43, 8'h00, 32'h104);
        bp[5] = mk(8'h46, 8'h47, 8'h48, 8'h00, 32'h105);
        k = 0; acc_n = 0;
        for (int c = 0; c < 5; c++) begin
            step(1, bp[k], 0, 0, 0);
            if (last_acc) begin k++; acc_n++; end
        end
        chk("bp_accepts", acc_n, 2);
        chk("bp_in_ready", in_ready, 0);
        for (int c = 0; c < 12 && k < 6; c++) begin
            step(1, bp[k], 0, 1, 0);
            if (last_acc) k++;
        end
        chk("bp_all_sent", k, 6);
        drain();
        chk_dict("after_bp");

        // Reset with two messages in flight.
        step(1, mk(8'h50, 8'h51, 8'h52, 8'h00, 32'h200), 0, 0, 0);
        step(1, mk(8'h50, 8'h51, 8'h52, 8'h00, 32'h201), 0, 0, 0);
        chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
        step(0, '0, 0, 1, 1);
        chk("rst_mid", {out_valid, msg_count, in_ready}, {1'b0, 16'h0, 1'b1});
        step(1, mk(8'h50, 8'h51, 8'h52, 8'h00, 32'h202), 0, 1, 0);
        step(0, '0, 0, 0, 0);
        chk("post_rst_pmap", out_fast[343:328], 16'h8000);
        drain();
        chk_dict("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
